// File: rtl/hydro_peak_pkg.sv
// Shared types and helpers for the hydrophone peak detector.
// The magnitude helper is only referenced when PEAK_ABS_EN is defined.
package hydro_peak_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    STALL = 1'b1
  } state_e;

  // Each input beat carries this many channels, low lane first.
  localparam int LANES = 2;

  function automatic int lane_of(input int ch);
    return ch % LANES;
  endfunction

  function automatic int beat_of(input int ch);
    return ch / LANES;
  endfunction

  // |x| of a w-bit value held sign-extended in 64 bits; the most negative code saturates.
  function automatic logic [63:0] sat_abs(input logic [63:0] x, input int w);
    logic [63:0] most_neg;
    most_neg = {64{1'b1}} << (w - 1);
    if (!x[63]) return x;
    if (x == most_neg) return ~most_neg;
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/hydro_peak_detector_if.sv
// Stream bundle around the peak detector: sample input and window-result output.
interface hydro_peak_detector_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int IDX_W    = 9
);
  logic [2*SAMPLE_W-1:0]      s_tdata;
  logic                       s_tvalid;
  logic                       s_tready;
  logic                       s_tlast;
  logic [NUM_CH*SAMPLE_W-1:0] m_tdata;
  logic [NUM_CH*IDX_W-1:0]    m_tuser;
  logic                       m_tvalid;
  logic                       m_tready;
  logic                       m_tlast;
  logic                       frame_err;

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tuser, m_tvalid, m_tlast, frame_err
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tuser, m_tvalid, m_tlast, frame_err
  );
endinterface

// File: rtl/peak_channel.sv
// One channel's running peak and the frame index where it occurred.
// PEAK_ABS_EN selects saturated magnitude compare instead of signed compare.
module peak_channel
  import hydro_peak_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int IDX_W    = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                update_i,
  input  logic                first_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [IDX_W-1:0]    idx_i,
  output logic [SAMPLE_W-1:0] peak_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic [SAMPLE_W-1:0] peak_nxt_o,
  output logic [IDX_W-1:0]    idx_nxt_o
);

  logic [SAMPLE_W-1:0] key;
  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

`ifdef PEAK_ABS_EN
  logic [63:0] mag;
  assign mag = sat_abs({{(64-SAMPLE_W){sample_i[SAMPLE_W-1]}}, sample_i}, SAMPLE_W);
  assign key = mag[SAMPLE_W-1:0];
`else
  assign key = sample_i;
`endif

  // Strictly greater keeps the earliest frame on ties; magnitudes never set the sign bit.
  always_comb begin
    peak_d = peak_q;
    idx_d  = idx_q;
    if (update_i && (first_i || ($signed(key) > $signed(peak_q)))) begin
      peak_d = key;
      idx_d  = idx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_q <= '0;
      idx_q  <= '0;
    end else begin
      peak_q <= peak_d;
      idx_q  <= idx_d;
    end
  end

  assign peak_o     = peak_q;
  assign idx_o      = idx_q;
  assign peak_nxt_o = peak_d;
  assign idx_nxt_o  = idx_d;

endmodule

// File: rtl/hydro_peak_detector.sv
// Windowed per-channel peak detector over a two-lane sample stream.
// Define PEAK_ABS_EN to track saturated magnitudes instead of signed samples.
module hydro_peak_detector
  import hydro_peak_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int SAMPLE_W      = 16,
  parameter int WINDOW_FRAMES = 500,
  parameter int IDX_W         = $clog2(WINDOW_FRAMES)
) (
  input  logic                       s_axis_aclk,
  input  logic                       s_axis_aresetn,
  input  logic [2*SAMPLE_W-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [NUM_CH*SAMPLE_W-1:0] m_axis_tdata,
  output logic [NUM_CH*IDX_W-1:0]    m_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       frame_err
);

  localparam int NUM_BEATS = NUM_CH / LANES;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(NUM_BEATS - 1);
  localparam logic [IDX_W-1:0]  LAST_FRAME = IDX_W'(WINDOW_FRAMES - 1);

  state_e                     state_q, state_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [IDX_W-1:0]           frame_q, frame_d;
  logic                       m_valid_q, m_valid_d;
  logic [NUM_CH*SAMPLE_W-1:0] m_data_q, m_data_d;
  logic [NUM_CH*IDX_W-1:0]    m_user_q, m_user_d;
  logic                       frame_err_q, frame_err_d;
  logic                       accept, win_done, last_beat;

  logic [NUM_CH*SAMPLE_W-1:0] trk_val, trk_val_nxt;
  logic [NUM_CH*IDX_W-1:0]    trk_idx, trk_idx_nxt;

  assign s_axis_tready = s_axis_aresetn && (state_q != STALL);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign last_beat     = (beat_q == LAST_BEAT);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    peak_channel #(
      .SAMPLE_W (SAMPLE_W),
      .IDX_W    (IDX_W)
    ) u_ch (
      .clk        (s_axis_aclk),
      .rst_n      (s_axis_aresetn),
      .update_i   (accept && (beat_q == BEAT_W'(beat_of(gi)))),
      .first_i    (frame_q == '0),
      .sample_i   (s_axis_tdata[lane_of(gi)*SAMPLE_W +: SAMPLE_W]),
      .idx_i      (frame_q),
      .peak_o     (trk_val[gi*SAMPLE_W +: SAMPLE_W]),
      .idx_o      (trk_idx[gi*IDX_W +: IDX_W]),
      .peak_nxt_o (trk_val_nxt[gi*SAMPLE_W +: SAMPLE_W]),
      .idx_nxt_o  (trk_idx_nxt[gi*IDX_W +: IDX_W])
    );
  end

  // A tlast that disagrees with the beat position is an error either way; only tlast counts a frame.
  always_comb begin
    beat_d      = beat_q;
    frame_d     = frame_q;
    frame_err_d = 1'b0;
    win_done    = 1'b0;
    if (accept) begin
      frame_err_d = (s_axis_tlast != last_beat);
      beat_d      = (s_axis_tlast || last_beat) ? '0 : beat_q + BEAT_W'(1);
      if (s_axis_tlast) begin
        if (frame_q == LAST_FRAME) begin
          frame_d  = '0;
          win_done = 1'b1;
        end else begin
          frame_d = frame_q + IDX_W'(1);
        end
      end
    end
  end

  // ACCUM loads from the trackers' next values so the closing beat is included;
  // STALL reloads from the frozen tracker snapshot.
  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_user_d  = m_user_q;
    if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;
    case (state_q)
      ACCUM: begin
        if (win_done) begin
          if (!m_valid_q || m_axis_tready) begin
            m_valid_d = 1'b1;
            m_data_d  = trk_val_nxt;
            m_user_d  = trk_idx_nxt;
          end else begin
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (m_axis_tready) begin
          m_valid_d = 1'b1;
          m_data_d  = trk_val;
          m_user_d  = trk_idx;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state_q     <= ACCUM;
      beat_q      <= '0;
      frame_q     <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_user_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      frame_q     <= frame_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_user_q    <= m_user_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_valid_q;
  assign frame_err     = frame_err_q;

endmodule

// File: doc/hydro_peak_detector.md
HYDRO_PEAK_DETECTOR -- requirements
Module: hydro_peak_detector

Interface
REQ-001 SHALL have parameter NUM_CH, default 4; hydrophone channel count; even and >= 2.
REQ-002 SHALL have parameter SAMPLE_W, default 16; sample width in bits, two's complement.
REQ-003 SHALL have parameter WINDOW_FRAMES, default 500; frames per peak window; >= 2.
REQ-004 SHALL have parameter IDX_W, default $clog2(WINDOW_FRAMES); width of the frame index.
REQ-005 SHALL have port s_axis_aclk, in, 1; the only clock. Reset is synchronous and active-low.
REQ-006 SHALL have port s_axis_aresetn, in, 1; synchronous active-low reset.
REQ-007 SHALL have port s_axis_tdata, in, 2*SAMPLE_W; at frame beat k, the low lane is channel 2k and the high lane is channel 2k+1.
REQ-008 SHALL have ports s_axis_tvalid (in, 1), s_axis_tready (out, 1) and s_axis_tlast (in, 1); tlast marks the last beat of a frame.
REQ-009 SHALL have port m_axis_tdata, out, NUM_CH*SAMPLE_W; the peak of channel c is at [c*SAMPLE_W +: SAMPLE_W].
REQ-010 SHALL have port m_axis_tuser, out, NUM_CH*IDX_W; the frame index of each channel's peak, at [c*IDX_W +: IDX_W].
REQ-011 SHALL have ports m_axis_tvalid (out, 1), m_axis_tready (in, 1) and m_axis_tlast (out, 1); tlast equals tvalid.
REQ-012 SHALL have port frame_err, out, 1; one-cycle pulse on a framing error.

Function
REQ-013 SHALL accept an input beat only when s_axis_tvalid && s_axis_tready.
REQ-014 SHALL track the current beat 0..NUM_CH/2-1 with a beat counter; each accepted beat updates two channel trackers.
REQ-015 SHALL load each tracker unconditionally on the first frame of a window; afterwards it SHALL update on a strictly-greater sample, so ties keep the earliest frame.
REQ-016 SHALL capture the current frame counter (0..WINDOW_FRAMES-1) into the index on every tracker load or update.
REQ-017 SHALL treat tlast accepted at a beat other than the last as a framing error: frame_err pulses, the beat counter returns to 0, and the frame is counted.
REQ-018 SHALL treat a missing tlast on the last beat as a framing error: frame_err pulses, the beat counter wraps to 0, and the frame is not counted.
REQ-019 SHALL complete a window when tlast is accepted with frame counter == WINDOW_FRAMES-1; the frame counter wraps to 0.
REQ-020 SHALL run a state machine with states ACCUM and STALL.
REQ-021 SHALL, on window completion in ACCUM with the output register free or draining that cycle, load the output register on that edge: m_axis_tvalid is 1 in the next cycle, trackers re-arm, and there is no input gap.
REQ-022 SHALL, on window completion while m_axis_tvalid && !m_axis_tready, enter STALL: trackers hold the snapshot and s_axis_tready = 0.
REQ-023 SHALL, in STALL, on the cycle m_axis_tready = 1, reload the output from the snapshot (tvalid stays 1), return to ACCUM, and raise s_axis_tready the next cycle.
REQ-024 SHALL hold the m_axis outputs stable while m_axis_tvalid && !m_axis_tready.
REQ-025 SHALL drive s_axis_tready = s_axis_aresetn && (state != STALL).

Reset
REQ-026 SHALL, while s_axis_aresetn = 0 at a clock edge, clear every output to 0, clear all counters and trackers, and set the state to ACCUM.
REQ-027 SHALL discard a partial window on reset mid-window; after reset the first frame starts a new window at index 0.

Configuration
REQ-028 SHALL, with PEAK_ABS_EN defined, compare magnitudes |x|; the most negative value saturates to 2^(SAMPLE_W-1)-1, and m_axis_tdata carries the unsigned magnitude.
REQ-029 SHALL, without PEAK_ABS_EN, use signed compare; m_axis_tdata carries the raw signed sample.

Structure
REQ-030 SHALL place the state enum, lane/packing constants and the magnitude function in package hydro_peak_pkg.
REQ-031 SHALL implement the per-channel compare, value and index register as sub-module peak_channel, instantiated NUM_CH times.

Verification (NUM_CH=4, SAMPLE_W=16, WINDOW_FRAMES=4)
REQ-032 SHALL cover: ch0 samples 5, 9, 9, 3 over frames 0-3 -> peak 9, index 1 (tie keeps earlier).
REQ-033 SHALL cover: ch2 samples -100, -7, -300, -50 -> peak -7, index 1; with PEAK_ABS_EN -> peak 300, index 2.
REQ-034 SHALL cover: m_axis_tready = 0 through two window completions -> STALL entered, s_axis_tready = 0, both results delivered in order once tready rises.
REQ-035 SHALL cover: tlast on beat 0 of frame 2 -> frame_err pulses 1 cycle, and the result appears after one more full frame.
REQ-036 SHALL cover: reset asserted at frame 2 beat 1 -> all outputs 0; the next window is reported after 4 clean frames with indices 0..3.
REQ-037 SHALL cover: back-to-back windows with tready = 1 -> s_axis_tready never drops, and m_axis_tvalid pulses every 8 accepted beats.
